// File: rtl/nb_force_router.sv
// Neighbour-force router: drops home-cell entries, buffers the rest in a show-ahead FIFO,
// raises early back-pressure, and reports when a phase has fully drained.
//
// Drain FSM states:
//   state        | meaning
//   ST_RUN       | normal streaming, no phase end pending
//   ST_WAIT      | flushing the evaluation pipeline, 32-cycle down-counter running
//   ST_EMPTY_CHK | waiting for FIFO empty with no write before reporting drained
module nb_force_router #(
   parameter int CELL_ID_WIDTH       = 3,
   parameter int PARTICLE_ADDR_WIDTH = 7,
   parameter int HOME_CELL_X         = 0,
   parameter int HOME_CELL_Y         = 0,
   parameter int HOME_CELL_Z         = 0,
   parameter int FIFO_DEPTH          = 32,
   parameter int ALMOST_FULL_MARGIN  = 8,
   localparam int ID_W               = 3*CELL_ID_WIDTH + PARTICLE_ADDR_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ID_W-1:0]  in_nb_id,
   input  logic [95:0]      in_nb_force,
   input  logic             in_nb_valid,
   input  logic             in_phase_end,
   output logic [ID_W-1:0]  out_id,
   output logic [95:0]      out_force,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_almost_full,
   output logic             out_drained,
   output logic             out_overflow,
   output logic [15:0]      out_drop_count
);

   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int PW      = AW + 1;
   localparam int ENTRY_W = ID_W + 96;
   localparam logic [5:0] WAIT_LOAD = 6'd31;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_WAIT      = 2'd1,
      ST_EMPTY_CHK = 2'd2
   } drain_state_t;

   logic [ENTRY_W-1:0]        mem [FIFO_DEPTH];
   logic [PW-1:0]             wr_ptr, rd_ptr;
   logic [PW-1:0]             wr_ptr_nxt, rd_ptr_nxt, occ_nxt;
   logic [31:0]               free_nxt;
   logic [CELL_ID_WIDTH-1:0]  cell_x, cell_y, cell_z;
   logic                      is_home;
   logic                      fifo_empty, fifo_full;
   logic                      pop, wr_en, drop;
   logic                      almost_full_q, overflow_q, drained_q;
   logic [15:0]               drop_count_q;

   drain_state_t              state, state_nxt;
   logic [5:0]                wait_cnt, wait_cnt_nxt;
   logic                      drained_nxt;

   assign cell_x = in_nb_id[ID_W-1 -: CELL_ID_WIDTH];
   assign cell_y = in_nb_id[ID_W-1-CELL_ID_WIDTH -: CELL_ID_WIDTH];
   assign cell_z = in_nb_id[PARTICLE_ADDR_WIDTH +: CELL_ID_WIDTH];

   assign is_home = (cell_x == CELL_ID_WIDTH'(HOME_CELL_X)) &&
                    (cell_y == CELL_ID_WIDTH'(HOME_CELL_Y)) &&
                    (cell_z == CELL_ID_WIDTH'(HOME_CELL_Z));

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A pop at full frees the slot this same cycle, so a concurrent write is still accepted.
   assign pop   = !fifo_empty && out_ready;
   assign wr_en = in_nb_valid && !is_home && (!fifo_full || pop);
   assign drop  = in_nb_valid && !is_home && fifo_full && !pop;

   assign wr_ptr_nxt = wr_ptr + PW'(wr_en);
   assign rd_ptr_nxt = rd_ptr + PW'(pop);
   assign occ_nxt    = wr_ptr_nxt - rd_ptr_nxt;
   assign free_nxt   = 32'(FIFO_DEPTH) - 32'(occ_nxt);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= {in_nb_id, in_nb_force};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         almost_full_q <= 1'b0;
         overflow_q    <= 1'b0;
         drop_count_q  <= '0;
      end else begin
         wr_ptr        <= wr_ptr_nxt;
         rd_ptr        <= rd_ptr_nxt;
         almost_full_q <= (free_nxt <= 32'(ALMOST_FULL_MARGIN));
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_count_q != 16'hFFFF) begin
               drop_count_q <= drop_count_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         wait_cnt  <= '0;
         drained_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         drained_q <= drained_nxt;
      end
   end

   // A new phase end always wins, restarting the pipeline flush window.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      drained_nxt  = 1'b0;
      case (state)
         ST_RUN: begin
            if (in_phase_end) begin
               state_nxt    = ST_WAIT;
               wait_cnt_nxt = WAIT_LOAD;
            end
         end
         ST_WAIT: begin
            if (in_phase_end) begin
               wait_cnt_nxt = WAIT_LOAD;
            end else if (wait_cnt == 6'd0) begin
               state_nxt = ST_EMPTY_CHK;
            end else begin
               wait_cnt_nxt = wait_cnt - 6'd1;
            end
         end
         ST_EMPTY_CHK: begin
            if (in_phase_end) begin
               state_nxt    = ST_WAIT;
               wait_cnt_nxt = WAIT_LOAD;
            end else if (fifo_empty && !wr_en) begin
               state_nxt   = ST_RUN;
               drained_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   assign out_valid          = !fifo_empty;
   assign {out_id, out_force} = mem[rd_ptr[AW-1:0]];
   assign out_almost_full    = almost_full_q;
   assign out_overflow       = overflow_q;
   assign out_drop_count     = drop_count_q;
   assign out_drained        = drained_q;

endmodule

// File: tb/tb_nb_force_router.sv
// Directed bench for nb_force_router: queue-based reference model checked every cycle,
// plus hand-computed literal checks for the filter, back-pressure, overflow and drain timing.
module tb_nb_force_router;

   localparam int CW     = 3;
   localparam int AW     = 7;
   localparam int IDW    = 3*CW + AW;
   localparam int DEPTH  = 32;
   localparam int MARGIN = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [IDW-1:0]  in_nb_id;
   logic [95:0]     in_nb_force;
   logic            in_nb_valid;
   logic            in_phase_end;
   logic [IDW-1:0]  out_id;
   logic [95:0]     out_force;
   logic            out_valid;
   logic            out_ready;
   logic            out_almost_full;
   logic            out_drained;
   logic            out_overflow;
   logic [15:0]     out_drop_count;

   always #5 clk = ~clk;

   nb_force_router #(
      .CELL_ID_WIDTH(CW), .PARTICLE_ADDR_WIDTH(AW),
      .HOME_CELL_X(1), .HOME_CELL_Y(1), .HOME_CELL_Z(1),
      .FIFO_DEPTH(DEPTH), .ALMOST_FULL_MARGIN(MARGIN)
   ) dut (
      .clk(clk), .rst(rst),
      .in_nb_id(in_nb_id), .in_nb_force(in_nb_force),
      .in_nb_valid(in_nb_valid), .in_phase_end(in_phase_end),
      .out_id(out_id), .out_force(out_force), .out_valid(out_valid),
      .out_ready(out_ready), .out_almost_full(out_almost_full),
      .out_drained(out_drained), .out_overflow(out_overflow),
      .out_drop_count(out_drop_count)
   );

   int  n_vec = 0;
   int  n_err = 0;
   bit  chk_en = 1'b0;
   int  ser = 0;

   function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference model: a plain queue of accepted entries plus elapsed-time drain tracking.
   logic [IDW+95:0] mq[$];
   logic [IDW+95:0] hd;
   bit              m_ovf = 1'b0;
   logic [15:0]     m_drops = '0;
   bit              m_pend = 1'b0;
   int              m_since = 0;
   bit              m_drained = 1'b0;
   bit              m_pop, m_home, m_wr;
   int              m_sz;

   always @(posedge clk) begin
      m_sz = mq.size();
      if (rst) begin
         mq.delete();
         m_ovf = 1'b0;
         m_drops = '0;
         m_pend = 1'b0;
         m_since = 0;
         m_drained = 1'b0;
      end else begin
         m_pop  = (m_sz > 0) && out_ready;
         m_home = (in_nb_id[IDW-1 -: CW] == 3'd1) && (in_nb_id[IDW-1-CW -: CW] == 3'd1) &&
                  (in_nb_id[AW +: CW] == 3'd1);
         m_wr   = in_nb_valid && !m_home && ((m_sz < DEPTH) || m_pop);
         m_drained = 1'b0;
         if (in_phase_end) begin
            m_pend = 1'b1;
            m_since = 0;
         end else if (m_pend) begin
            if (m_since >= 32 && m_sz == 0 && !m_wr) begin
               m_drained = 1'b1;
               m_pend = 1'b0;
            end else begin
               m_since++;
            end
         end
         if (m_pop) void'(mq.pop_front());
         if (m_wr) begin
            mq.push_back({in_nb_id, in_nb_force});
         end else if (in_nb_valid && !m_home) begin
            m_ovf = 1'b1;
            if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid", out_valid, mq.size() > 0);
         if (mq.size() > 0) begin
            hd = mq[0];
            chk("id", out_id, hd[IDW+95:96]);
            chk("force", out_force, hd[95:0]);
         end
         chk("almost_full", out_almost_full, (DEPTH - mq.size()) <= MARGIN);
         chk("overflow", out_overflow, m_ovf);
         chk("drop_count", out_drop_count, m_drops);
         chk("drained", out_drained, m_drained);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_new();
      in_nb_valid = 1'b1;
      in_nb_id    = {3'd2, 3'(ser / 128), 3'd3, 7'(ser)};
      in_nb_force = {32'(ser) ^ 32'hA5A5_0000, 32'(ser * 3), 32'(ser + 7)};
      ser++;
      cyc();
      in_nb_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // Counts cycles from the phase-end cycle until out_drained is seen, bounded.
   task automatic measure_drain(input string nm);
      int  k;
      bit  found;
      k = 1;
      found = 1'b0;
      while (k <= 60 && !found) begin
         @(negedge clk);
         if (out_drained) found = 1'b1;
         else begin
            cyc();
            k++;
         end
      end
      chk(nm, k, 34);
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_nb_valid = 1'b0; in_phase_end = 1'b0; out_ready = 1'b0;
      in_nb_id = '0; in_nb_force = '0;
      cyc();
      chk_en = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_af", out_almost_full, 1'b0);
      chk("rst_ovf", out_overflow, 1'b0);
      chk("rst_drops", out_drop_count, 16'd0);
      chk("rst_drained", out_drained, 1'b0);
      cyc();

      // Home filter
      out_ready = 1'b1;
      in_nb_valid = 1'b1;
      in_nb_id = {3'd1, 3'd1, 3'd1, 7'd5};
      in_nb_force = {3{32'h3F80_0000}};
      cyc();
      in_nb_valid = 1'b0;
      @(negedge clk);
      chk("home_dropped", out_valid, 1'b0);
      in_nb_valid = 1'b1;
      in_nb_id = {3'd2, 3'd1, 3'd1, 7'd5};
      cyc();
      in_nb_valid = 1'b0;
      @(negedge clk);
      chk("nonhome_valid", out_valid, 1'b1);
      chk("nonhome_id", out_id, 16'h4485);
      chk("nonhome_force", out_force, 96'h3F800000_3F800000_3F800000);
      idle(3);

      // Burst with stalled consumer
      out_ready = 1'b0;
      for (int i = 0; i < 24; i++) begin
         push_new();
         if (i == 22) begin
            @(negedge clk);
            chk("af_at_23", out_almost_full, 1'b0);
         end
      end
      @(negedge clk);
      chk("af_at_24", out_almost_full, 1'b1);
      chk("burst_drops", out_drop_count, 16'd0);
      out_ready = 1'b1;
      idle(26);

      // Overflow
      out_ready = 1'b0;
      for (int i = 0; i < 34; i++) push_new();
      @(negedge clk);
      chk("ovf_flag", out_overflow, 1'b1);
      chk("ovf_drops", out_drop_count, 16'd2);
      out_ready = 1'b1;
      idle(34);

      // Full with simultaneous pop
      out_ready = 1'b0;
      for (int i = 0; i < 32; i++) push_new();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push_new();
         @(negedge clk);
         chk("full_pop_af", out_almost_full, 1'b1);
         chk("full_pop_drops", out_drop_count, 16'd2);
      end
      idle(34);

      // Drain
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_new();
      out_ready = 1'b1;
      in_phase_end = 1'b1;
      cyc();
      in_phase_end = 1'b0;
      measure_drain("drain_latency");
      idle(4);
      in_phase_end = 1'b1;
      cyc();
      in_phase_end = 1'b0;
      idle(9);
      in_phase_end = 1'b1;
      cyc();
      in_phase_end = 1'b0;
      measure_drain("drain_restart_latency");
      idle(4);

      // Reset mid-operation with the FSM waiting
      out_ready = 1'b0;
      for (int i = 0; i < 7; i++) push_new();
      in_phase_end = 1'b1;
      cyc();
      in_phase_end = 1'b0;
      idle(3);
      @(negedge clk);
      chk("pre_rst_ovf", out_overflow, 1'b1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", out_valid, 1'b0);
      chk("post_rst_ovf", out_overflow, 1'b0);
      chk("post_rst_drops", out_drop_count, 16'd0);
      idle(45);
      out_ready = 1'b1;
      push_new();
      in_phase_end = 1'b1;
      cyc();
      in_phase_end = 1'b0;
      measure_drain("post_rst_drain_latency");
      idle(3);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
